// File: rtl/multicycle_control_if.sv
// Shared-memory handshake between the multicycle controller and the memory.
// The controller drives the request side; the memory answers with mem_ready.
interface multicycle_control_if;
  logic mem_req;
  logic mem_we;
  logic i_or_d;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output i_or_d, input mem_ready);
  modport slave  (input mem_req, input mem_we, input i_or_d, output mem_ready);
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: sequences fetch/decode/execute/memory/write-back,
// with a sticky trap on illegal opcodes and a retired-instruction counter.
module multicycle_control #(
  parameter logic [31:0] RETIRED_INIT = 32'd0  // counter value loaded by reset
) (
  input  logic                        clock,
  input  logic                        reset_n,
  multicycle_control_if.master        mem,
  input  logic [5:0]                  opcode,
  input  logic [5:0]                  funct,
  output logic                        ir_write,
  output logic                        pc_write,
  output logic                        pc_write_cond,
  output logic [1:0]                  pc_src,
  output logic                        alu_src_a,
  output logic [1:0]                  alu_src_b,
  output logic [2:0]                  alu_op,
  output logic                        reg_write,
  output logic [1:0]                  reg_dst,
  output logic [1:0]                  mem_to_reg,
  output logic [3:0]                  state,
  output logic                        trap,
  output logic [31:0]                 retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWR  = 4'd4,
    S_RWB    = 4'd5,
    S_LWB    = 4'd6,
    S_IWB    = 4'd7,
    S_TRAP   = 4'd8
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t      state_reg, state_next;
  logic        trap_reg;
  logic [31:0] retired_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_FETCH;
      trap_reg    <= 1'b0;
      retired_reg <= RETIRED_INIT;
    end else begin
      state_reg <= state_next;
      if (state_next == S_TRAP)
        trap_reg <= 1'b1;
      if (state_reg != S_FETCH && state_next == S_FETCH)
        retired_reg <= retired_reg + 32'd1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.i_or_d    = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'd0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = 3'd0;
    reg_write     = 1'b0;
    reg_dst       = 2'd0;
    mem_to_reg    = 2'd0;

    // Outputs are gated by reset so no memory strobe outlives reset_n going low.
    if (reset_n) begin
      case (state_reg)
        S_FETCH: begin
          mem.mem_req = 1'b1;
          if (mem.mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            alu_src_b  = 2'd1;
            state_next = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'd3;
          case (opcode)
            OP_RTYPE: begin
              if (funct == FN_JR) begin
                pc_write   = 1'b1;
                pc_src     = 2'd3;
                state_next = S_FETCH;
              end else begin
                state_next = S_EXEC;
              end
            end
            OP_LW, OP_SW, OP_BEQ, OP_ADDI: state_next = S_EXEC;
            OP_J: begin
              pc_write   = 1'b1;
              pc_src     = 2'd2;
              state_next = S_FETCH;
            end
            OP_JAL: begin
              pc_write   = 1'b1;
              pc_src     = 2'd2;
              reg_write  = 1'b1;
              reg_dst    = 2'd2;
              mem_to_reg = 2'd2;
              state_next = S_FETCH;
            end
            default: state_next = S_TRAP;
          endcase
        end
        S_EXEC: begin
          case (opcode)
            OP_RTYPE: begin
              alu_src_a  = 1'b1;
              alu_op     = 3'd2;
              state_next = S_RWB;
            end
            OP_LW, OP_SW, OP_ADDI: begin
              alu_src_a = 1'b1;
              alu_src_b = 2'd2;
              if (opcode == OP_LW)
                state_next = S_MEMRD;
              else if (opcode == OP_SW)
                state_next = S_MEMWR;
              else
                state_next = S_IWB;
            end
            OP_BEQ: begin
              alu_src_a     = 1'b1;
              alu_op        = 3'd1;
              pc_write_cond = 1'b1;
              pc_src        = 2'd1;
              state_next    = S_FETCH;
            end
            default: state_next = S_TRAP;
          endcase
        end
        S_MEMRD: begin
          mem.mem_req = 1'b1;
          mem.i_or_d  = 1'b1;
          if (mem.mem_ready)
            state_next = S_LWB;
        end
        S_MEMWR: begin
          mem.mem_req = 1'b1;
          mem.mem_we  = 1'b1;
          mem.i_or_d  = 1'b1;
          if (mem.mem_ready)
            state_next = S_FETCH;
        end
        S_RWB: begin
          reg_write  = 1'b1;
          reg_dst    = 2'd1;
          state_next = S_FETCH;
        end
        S_LWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'd1;
          state_next = S_FETCH;
        end
        S_IWB: begin
          reg_write  = 1'b1;
          state_next = S_FETCH;
        end
        S_TRAP:  state_next = S_TRAP;
        default: state_next = S_TRAP;
      endcase
    end
  end

  assign state   = state_reg;
  assign trap    = trap_reg;
  assign retired = retired_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a vector table walks every instruction
// class, then hand sequences cover trap, async reset mid-write and counter wrap.
module tb_multicycle_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BAD  = 6'b111111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_JR   = 6'b001000;

  // Control word: req we iod irw pcw pcwc pcsrc(2) asa asb(2) aop(3) rw rdst(2) m2r(2)
  localparam logic [18:0] CW_FWAIT = 19'b1_0_0_0_0_0_00_0_00_000_0_00_00;
  localparam logic [18:0] CW_FRDY  = 19'b1_0_0_1_1_0_00_0_01_000_0_00_00;
  localparam logic [18:0] CW_DEC   = 19'b0_0_0_0_0_0_00_0_11_000_0_00_00;
  localparam logic [18:0] CW_DJR   = 19'b0_0_0_0_1_0_11_0_11_000_0_00_00;
  localparam logic [18:0] CW_DJ    = 19'b0_0_0_0_1_0_10_0_11_000_0_00_00;
  localparam logic [18:0] CW_DJAL  = 19'b0_0_0_0_1_0_10_0_11_000_1_10_10;
  localparam logic [18:0] CW_EXR   = 19'b0_0_0_0_0_0_00_1_00_010_0_00_00;
  localparam logic [18:0] CW_EXM   = 19'b0_0_0_0_0_0_00_1_10_000_0_00_00;
  localparam logic [18:0] CW_EXB   = 19'b0_0_0_0_0_1_01_1_00_001_0_00_00;
  localparam logic [18:0] CW_MRD   = 19'b1_0_1_0_0_0_00_0_00_000_0_00_00;
  localparam logic [18:0] CW_MWR   = 19'b1_1_1_0_0_0_00_0_00_000_0_00_00;
  localparam logic [18:0] CW_RWB   = 19'b0_0_0_0_0_0_00_0_00_000_1_01_00;
  localparam logic [18:0] CW_LWB   = 19'b0_0_0_0_0_0_00_0_00_000_1_00_01;
  localparam logic [18:0] CW_IWB   = 19'b0_0_0_0_0_0_00_0_00_000_1_00_00;
  localparam logic [18:0] CW_ZERO  = 19'd0;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Main DUT
  logic        reset_n;
  logic [5:0]  opcode, funct;
  logic        ir_write, pc_write, pc_write_cond, alu_src_a, reg_write, trap;
  logic [1:0]  pc_src, alu_src_b, reg_dst, mem_to_reg;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic [31:0] retired;
  multicycle_control_if bus ();

  multicycle_control dut (
    .clock(clock), .reset_n(reset_n), .mem(bus.master),
    .opcode(opcode), .funct(funct),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .state(state), .trap(trap), .retired(retired)
  );

  logic [18:0] cw;
  assign cw = {bus.mem_req, bus.mem_we, bus.i_or_d, ir_write, pc_write, pc_write_cond,
               pc_src, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg};

  // Second instance, preloaded just below the wrap point of the retired counter
  logic        w_reset_n;
  logic        w_ir_write, w_pc_write, w_pc_write_cond, w_alu_src_a, w_reg_write, w_trap;
  logic [1:0]  w_pc_src, w_alu_src_b, w_reg_dst, w_mem_to_reg;
  logic [2:0]  w_alu_op;
  logic [3:0]  w_state;
  logic [31:0] w_retired;
  multicycle_control_if w_bus ();

  multicycle_control #(.RETIRED_INIT(32'hFFFF_FFFF)) dut_wrap (
    .clock(clock), .reset_n(w_reset_n), .mem(w_bus.master),
    .opcode(OP_J), .funct(6'd0),
    .ir_write(w_ir_write), .pc_write(w_pc_write), .pc_write_cond(w_pc_write_cond),
    .pc_src(w_pc_src), .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b), .alu_op(w_alu_op),
    .reg_write(w_reg_write), .reg_dst(w_reg_dst), .mem_to_reg(w_mem_to_reg),
    .state(w_state), .trap(w_trap), .retired(w_retired)
  );

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        mr;
    logic [3:0]  st;
    logic [18:0] cw;
    logic [31:0] ret;
  } vec_t;

  vec_t tbl[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic mr,
                     input logic [3:0] st, input logic [18:0] c, input logic [31:0] ret);
    vec_t v;
    v.op = op; v.fn = fn; v.mr = mr; v.st = st; v.cw = c; v.ret = ret;
    tbl.push_back(v);
  endtask

  // Apply inputs just after a falling edge and sample 1 time unit later.
  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic mr);
    opcode = op; funct = fn; bus.mem_ready = mr;
    #1;
  endtask

  initial begin
    reset_n = 1'b0; w_reset_n = 1'b0;
    opcode = OP_R; funct = FN_ADD; bus.mem_ready = 1'b0; w_bus.mem_ready = 1'b1;

    // add: 0,1,2,5,0
    add(OP_R,    FN_ADD, 1'b0, 4'd0, CW_FWAIT, 32'd0);
    add(OP_R,    FN_ADD, 1'b1, 4'd0, CW_FRDY,  32'd0);
    add(OP_R,    FN_ADD, 1'b1, 4'd1, CW_DEC,   32'd0);
    add(OP_R,    FN_ADD, 1'b1, 4'd2, CW_EXR,   32'd0);
    add(OP_R,    FN_ADD, 1'b1, 4'd5, CW_RWB,   32'd0);
    // lw with 3 wait cycles in MEMRD
    add(OP_LW,   6'd0,   1'b1, 4'd0, CW_FRDY,  32'd1);
    add(OP_LW,   6'd0,   1'b0, 4'd1, CW_DEC,   32'd1);
    add(OP_LW,   6'd0,   1'b0, 4'd2, CW_EXM,   32'd1);
    add(OP_LW,   6'd0,   1'b0, 4'd3, CW_MRD,   32'd1);
    add(OP_LW,   6'd0,   1'b0, 4'd3, CW_MRD,   32'd1);
    add(OP_LW,   6'd0,   1'b0, 4'd3, CW_MRD,   32'd1);
    add(OP_LW,   6'd0,   1'b1, 4'd3, CW_MRD,   32'd1);
    add(OP_LW,   6'd0,   1'b0, 4'd6, CW_LWB,   32'd1);
    // sw
    add(OP_SW,   6'd0,   1'b1, 4'd0, CW_FRDY,  32'd2);
    add(OP_SW,   6'd0,   1'b1, 4'd1, CW_DEC,   32'd2);
    add(OP_SW,   6'd0,   1'b1, 4'd2, CW_EXM,   32'd2);
    add(OP_SW,   6'd0,   1'b1, 4'd4, CW_MWR,   32'd2);
    // addi
    add(OP_ADDI, 6'd0,   1'b1, 4'd0, CW_FRDY,  32'd3);
    add(OP_ADDI, 6'd0,   1'b1, 4'd1, CW_DEC,   32'd3);
    add(OP_ADDI, 6'd0,   1'b1, 4'd2, CW_EXM,   32'd3);
    add(OP_ADDI, 6'd0,   1'b1, 4'd7, CW_IWB,   32'd3);
    // beq
    add(OP_BEQ,  6'd0,   1'b1, 4'd0, CW_FRDY,  32'd4);
    add(OP_BEQ,  6'd0,   1'b1, 4'd1, CW_DEC,   32'd4);
    add(OP_BEQ,  6'd0,   1'b1, 4'd2, CW_EXB,   32'd4);
    // j, jal, jr
    add(OP_J,    6'd0,   1'b1, 4'd0, CW_FRDY,  32'd5);
    add(OP_J,    6'd0,   1'b1, 4'd1, CW_DJ,    32'd5);
    add(OP_JAL,  6'd0,   1'b1, 4'd0, CW_FRDY,  32'd6);
    add(OP_JAL,  6'd0,   1'b1, 4'd1, CW_DJAL,  32'd6);
    add(OP_R,    FN_JR,  1'b1, 4'd0, CW_FRDY,  32'd7);
    add(OP_R,    FN_JR,  1'b1, 4'd1, CW_DJR,   32'd7);
    add(OP_R,    FN_ADD, 1'b0, 4'd0, CW_FWAIT, 32'd8);
    add(OP_R,    FN_ADD, 1'b0, 4'd0, CW_FWAIT, 32'd8);

    // Reset state, no clock edge yet
    #1;
    check("reset_state",   {28'd0, state}, 32'd0);
    check("reset_trap",    {31'd0, trap},  32'd0);
    check("reset_retired", retired,        32'd0);
    check("reset_mem_req", {31'd0, bus.mem_req}, 32'd0);

    @(negedge clock);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].fn, tbl[i].mr);
      $display("[TB] row %0d op=%b mr=%b state=%0d cw=%b retired=%0d",
               i, tbl[i].op, tbl[i].mr, state, cw, retired);
      check($sformatf("row%0d_state", i),   {28'd0, state}, {28'd0, tbl[i].st});
      check($sformatf("row%0d_ctrl", i),    {13'd0, cw},    {13'd0, tbl[i].cw});
      check($sformatf("row%0d_retired", i), retired,        tbl[i].ret);
      @(negedge clock);
    end

    // Illegal opcode: DECODE then absorbing TRAP
    drive(OP_BAD, 6'd0, 1'b1);
    @(negedge clock);
    drive(OP_BAD, 6'd0, 1'b0);
    check("bad_decode_state", {28'd0, state}, 32'd1);
    check("bad_decode_ctrl",  {13'd0, cw},    {13'd0, CW_DEC});
    @(negedge clock);
    for (int c = 0; c < 20; c++) begin
      drive(OP_R, FN_ADD, c[0]);
      $display("[TB] trap cycle %0d state=%0d trap=%b cw=%b retired=%0d", c, state, trap, cw, retired);
      check($sformatf("trap%0d_state", c), {28'd0, state}, 32'd8);
      check($sformatf("trap%0d_flag", c),  {31'd0, trap},  32'd1);
      check($sformatf("trap%0d_ctrl", c),  {13'd0, cw},    {13'd0, CW_ZERO});
      check($sformatf("trap%0d_retired", c), retired,      32'd8);
      @(negedge clock);
    end

    // Async reset between edges clears trap and counter
    #2 reset_n = 1'b0;
    #1;
    check("trap_rst_state",   {28'd0, state}, 32'd0);
    check("trap_rst_flag",    {31'd0, trap},  32'd0);
    check("trap_rst_retired", retired,        32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // First access after reset is an instruction fetch
    drive(OP_SW, 6'd0, 1'b0);
    $display("[TB] post-reset fetch state=%0d cw=%b", state, cw);
    check("post_rst_fetch", {13'd0, cw}, {13'd0, CW_FWAIT});
    drive(OP_SW, 6'd0, 1'b1);
    @(negedge clock);
    drive(OP_SW, 6'd0, 1'b0);
    @(negedge clock);
    drive(OP_SW, 6'd0, 1'b0);
    @(negedge clock);
    drive(OP_SW, 6'd0, 1'b0);
    $display("[TB] memwr before reset state=%0d cw=%b", state, cw);
    check("memwr_state", {28'd0, state}, 32'd4);
    check("memwr_we",    {31'd0, bus.mem_we}, 32'd1);
    // Reset pulse lands 3 time units after the falling edge, well before the next rising edge
    #2 reset_n = 1'b0;
    #1;
    $display("[TB] memwr after reset state=%0d cw=%b", state, cw);
    check("memwr_rst_we",    {31'd0, bus.mem_we},  32'd0);
    check("memwr_rst_req",   {31'd0, bus.mem_req}, 32'd0);
    check("memwr_rst_state", {28'd0, state},       32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    drive(OP_R, FN_ADD, 1'b0);
    check("memwr_rel_fetch", {13'd0, cw}, {13'd0, CW_FWAIT});

    // Counter wrap on the preloaded instance running back-to-back jumps
    @(negedge clock);
    w_reset_n = 1'b1;
    #1;
    check("wrap_preload", w_retired, 32'hFFFF_FFFF);
    @(negedge clock);
    @(negedge clock);
    #1;
    $display("[TB] wrap retired=%h state=%0d", w_retired, w_state);
    check("wrap_zero",  w_retired, 32'd0);
    check("wrap_state", {28'd0, w_state}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    #1;
    check("wrap_one", w_retired, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
